// File: rtl/apb_slave_pkg.sv
// Shared types and constants for the APB completer and its register file.
package apb_slave_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } apb_slv_state_t;

  localparam int REG_CTRL     = 0;
  localparam int REG_STATUS   = 1;
  localparam int REG_SCRATCH0 = 2;

  localparam int CTRL_WAIT_W  = 4;

endpackage

// File: rtl/apb_slave_regfile.sv
// Register file behind the APB completer: CTRL, STATUS counters, scratch words,
// combinational read mux and access error decode.
module apb_slave_regfile
  import apb_slave_pkg::*;
#(
  parameter logic [31:0]            BASE_ADDR    = 32'hA000,
  parameter int                     NUM_REGS     = 8,
  parameter logic [CTRL_WAIT_W-1:0] WAIT_DEFAULT = 4'd0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [31:0]            addr,
  input  logic                   write,
  input  logic [31:0]            wdata,
  input  logic                   commit,
  output logic [31:0]            rdata,
  output logic                   err,
  output logic [CTRL_WAIT_W-1:0] ctrl_wait
);

  logic [CTRL_WAIT_W-1:0] ctrl_q;
  logic [15:0]            rd_cnt;
  logic [15:0]            wr_cnt;
  logic [31:0]            scratch [REG_SCRATCH0:NUM_REGS-1];
  logic [29:0]            idx;

  assign ctrl_wait = ctrl_q;

  // Addresses below the base wrap to a huge index; the explicit compare below catches them anyway.
  assign idx = addr[31:2] - BASE_ADDR[31:2];

  assign err = (addr < BASE_ADDR)
            || (idx >= 30'(NUM_REGS))
            || (addr[1:0] != 2'b00)
            || (write && (idx == 30'(REG_STATUS)));

  always_comb begin
    // NOTE: default assignment first so no path leaves rdata unassigned and infers a latch.
    rdata = '0;
    if (!err && !write) begin
      if (idx == 30'(REG_CTRL)) begin
        rdata = 32'(ctrl_q);
      end else if (idx == 30'(REG_STATUS)) begin
        rdata = {rd_cnt, wr_cnt};
      end else begin
        for (int i = REG_SCRATCH0; i < NUM_REGS; i++) begin
          if (idx == 30'(i)) rdata = scratch[i];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q <= WAIT_DEFAULT;
      rd_cnt <= '0;
      wr_cnt <= '0;
      // NOTE: the scratch array is small flops, not a RAM, so it can and must be cleared on reset.
      for (int i = REG_SCRATCH0; i < NUM_REGS; i++) scratch[i] <= '0;
    end else if (commit && !err) begin
      if (write) begin
        wr_cnt <= wr_cnt + 16'd1;
        if (idx == 30'(REG_CTRL)) ctrl_q <= wdata[CTRL_WAIT_W-1:0];
        for (int i = REG_SCRATCH0; i < NUM_REGS; i++) begin
          if (idx == 30'(i)) scratch[i] <= wdata;
        end
      end else begin
        rd_cnt <= rd_cnt + 16'd1;
      end
    end
  end

endmodule

// File: rtl/apb_slave.sv
// APB completer: wait-state FSM with registered pready/pslverr/prdata in front
// of a small register file. Commit happens at the edge that ends the response cycle.
module apb_slave
  import apb_slave_pkg::*;
#(
  parameter logic [31:0]            BASE_ADDR    = 32'hA000,
  parameter int                     NUM_REGS     = 8,
  parameter logic [CTRL_WAIT_W-1:0] WAIT_DEFAULT = 4'd0
) (
  input  logic        pclk,
  input  logic        preset,
  input  logic        psel,
  input  logic        penable,
  input  logic [31:0] paddr,
  input  logic        pwrite,
  input  logic [31:0] pwdata,
  output logic [31:0] prdata,
  output logic        pready,
  output logic        pslverr
);

  apb_slv_state_t         state;
  logic [CTRL_WAIT_W-1:0] cnt;
  logic [CTRL_WAIT_W-1:0] ctrl_wait;
  logic [31:0]            rdata;
  logic                   err;
  logic                   commit;

  // The master holds address/data stable until it sees pready, so the live bus is decoded.
  assign commit = (state == ST_RESP);

  apb_slave_regfile #(
    .BASE_ADDR    (BASE_ADDR),
    .NUM_REGS     (NUM_REGS),
    .WAIT_DEFAULT (WAIT_DEFAULT)
  ) u_regfile (
    .clk       (pclk),
    .rst       (preset),
    .addr      (paddr),
    .write     (pwrite),
    .wdata     (pwdata),
    .commit    (commit),
    .rdata     (rdata),
    .err       (err),
    .ctrl_wait (ctrl_wait)
  );

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      pready  <= 1'b0;
      pslverr <= 1'b0;
      prdata  <= '0;
    end else begin
      // NOTE: non-blocking throughout; these defaults make the response a one-cycle pulse.
      pready  <= 1'b0;
      pslverr <= 1'b0;
      prdata  <= '0;
      unique case (state)
        ST_IDLE: begin
          if (psel && penable) begin
            // Response lands W+1 cycles after the first access cycle, so W=0 skips waiting.
            if (ctrl_wait == '0) begin
              state   <= ST_RESP;
              pready  <= 1'b1;
              pslverr <= err;
              prdata  <= rdata;
            end else begin
              cnt   <= ctrl_wait - 4'd1;
              state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (!psel) begin
            state <= ST_IDLE;
          end else if (cnt == '0) begin
            state   <= ST_RESP;
            pready  <= 1'b1;
            pslverr <= err;
            prdata  <= rdata;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_slave.sv
// Directed self-checking bench for apb_slave: reset, data path, wait states,
// error responses, abort, back-to-back transfers and reset mid-transfer.
module tb_apb_slave;

  logic        pclk;
  logic        preset;
  logic        psel;
  logic        penable;
  logic [31:0] paddr;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  int          checks;
  int          failures;
  int          lat;
  logic [31:0] rd_data;
  logic        rd_err;

  apb_slave dut (
    .pclk    (pclk),
    .preset  (preset),
    .psel    (psel),
    .penable (penable),
    .paddr   (paddr),
    .pwrite  (pwrite),
    .pwdata  (pwdata),
    .prdata  (prdata),
    .pready  (pready),
    .pslverr (pslverr)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  // Call at posedge+1; returns at posedge+1 of the cycle after the response.
  // lat is the cycle offset of pready from the first access cycle A0.
  task automatic xfer(input logic [31:0] addr, input logic wr, input logic [31:0] data);
    psel = 1'b1; penable = 1'b0; paddr = addr; pwrite = wr; pwdata = data;
    @(posedge pclk); #1 penable = 1'b1;
    lat = -1; rd_data = '0; rd_err = 1'b0;
    for (int k = 0; k <= 40 && lat < 0; k++) begin
      @(negedge pclk);
      if (pready) begin
        lat = k; rd_data = prdata; rd_err = pslverr;
      end
    end
    if (lat < 0) begin
      failures++;
      $display("FAIL xfer_timeout addr=%h no pready within 40 cycles", addr);
    end
    @(posedge pclk); #1 psel = 1'b0; penable = 1'b0;
  endtask

  task automatic do_reset();
    preset = 1'b1; psel = 1'b0; penable = 1'b0;
    repeat (3) @(posedge pclk);
    @(negedge pclk);
    checks++;
    if ({pready, pslverr, prdata} !== 34'h0) begin
      failures++;
      $display("FAIL reset_outputs got pready=%b pslverr=%b prdata=%h exp all zero", pready, pslverr, prdata);
    end
    @(posedge pclk); #1 preset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    xfer(32'hA000, 1'b0, '0);
    checks++;
    if (lat !== 1) begin failures++; $display("FAIL reset_rd_latency got=%0d exp=1", lat); end
    checks++;
    if (rd_data !== 32'h0 || rd_err !== 1'b0) begin
      failures++; $display("FAIL reset_rd_ctrl got data=%h err=%b exp data=0 err=0", rd_data, rd_err);
    end
    @(negedge pclk);
    checks++;
    if (pready !== 1'b0 || prdata !== 32'h0) begin
      failures++; $display("FAIL reset_one_cycle_pready got pready=%b prdata=%h exp 0/0", pready, prdata);
    end
  endtask

  task automatic test_write_read();
    do_reset();
    xfer(32'hA008, 1'b1, 32'hDEADBEEF);
    checks++;
    if (lat !== 1 || rd_err !== 1'b0) begin
      failures++; $display("FAIL wr_scratch got lat=%0d err=%b exp lat=1 err=0", lat, rd_err);
    end
    xfer(32'hA008, 1'b0, '0);
    checks++;
    if (rd_data !== 32'hDEADBEEF) begin
      failures++; $display("FAIL rd_scratch got=%h exp=deadbeef", rd_data);
    end
    xfer(32'hA004, 1'b0, '0);
    checks++;
    if (rd_data !== 32'h0001_0001) begin
      failures++; $display("FAIL rd_status got=%h exp=00010001", rd_data);
    end
  endtask

  task automatic test_wait_states();
    // counters enter at rd=2 wr=1
    xfer(32'hA000, 1'b1, 32'h3);
    checks++;
    if (lat !== 1) begin failures++; $display("FAIL wait_ctrl_wr_latency got=%0d exp=1", lat); end
    xfer(32'hA008, 1'b0, '0);
    checks++;
    if (lat !== 4) begin failures++; $display("FAIL wait3_latency got=%0d exp=4", lat); end
    checks++;
    if (rd_data !== 32'hDEADBEEF) begin failures++; $display("FAIL wait3_data got=%h exp=deadbeef", rd_data); end
    @(negedge pclk);
    checks++;
    if (pready !== 1'b0) begin failures++; $display("FAIL wait3_one_cycle got pready=%b exp=0", pready); end
    @(posedge pclk); #1;
    xfer(32'hA000, 1'b0, '0);
    checks++;
    if (rd_data !== 32'h3 || lat !== 4) begin
      failures++; $display("FAIL wait3_ctrl_rd got data=%h lat=%0d exp data=3 lat=4", rd_data, lat);
    end
    xfer(32'hA000, 1'b1, 32'h0);
    // leaves rd=4 wr=3, CTRL.wait=0
  endtask

  task automatic test_errors();
    logic [31:0] addrs  [4];
    logic        writes [4];
    addrs  = '{32'hA004, 32'hA020, 32'hA00A, 32'h9FFC};
    writes = '{1'b1, 1'b0, 1'b0, 1'b0};
    xfer(32'hA004, 1'b0, '0);
    checks++;
    if (rd_data !== 32'h0004_0003) begin failures++; $display("FAIL err_status_before got=%h exp=00040003", rd_data); end
    for (int i = 0; i < 4; i++) begin
      xfer(addrs[i], writes[i], 32'hFFFF_FFFF);
      checks++;
      if (rd_err !== 1'b1 || rd_data !== 32'h0 || lat !== 1) begin
        failures++;
        $display("FAIL err_case%0d addr=%h got err=%b data=%h lat=%0d exp err=1 data=0 lat=1",
                 i, addrs[i], rd_err, rd_data, lat);
      end
    end
    xfer(32'hA004, 1'b0, '0);
    checks++;
    if (rd_data !== 32'h0005_0003) begin failures++; $display("FAIL err_status_after got=%h exp=00050003", rd_data); end
  endtask

  task automatic test_abort();
    bit seen;
    xfer(32'hA000, 1'b1, 32'h5);
    // rd=6 wr=4
    psel = 1'b1; penable = 1'b0; paddr = 32'hA00C; pwrite = 1'b1; pwdata = 32'h1234;
    @(posedge pclk); #1 penable = 1'b1;
    seen = 1'b0;
    @(negedge pclk); seen |= pready;
    @(posedge pclk); #1;
    @(negedge pclk); seen |= pready;
    @(posedge pclk); #1 psel = 1'b0; penable = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge pclk); seen |= pready;
    end
    checks++;
    if (seen !== 1'b0) begin failures++; $display("FAIL abort_pready got=1 exp=0"); end
    @(posedge pclk); #1;
    xfer(32'hA00C, 1'b0, '0);
    checks++;
    if (rd_data !== 32'h0 || lat !== 6) begin
      failures++; $display("FAIL abort_scratch got data=%h lat=%0d exp data=0 lat=6", rd_data, lat);
    end
    xfer(32'hA004, 1'b0, '0);
    checks++;
    if (rd_data !== 32'h0007_0004) begin failures++; $display("FAIL abort_status got=%h exp=00070004", rd_data); end
    xfer(32'hA000, 1'b1, 32'h0);
    // rd=8 wr=5, CTRL.wait=0
  endtask

  task automatic test_back_to_back();
    xfer(32'hA00C, 1'b1, 32'h1111_1111);
    xfer(32'hA00C, 1'b0, '0);
    checks++;
    if (rd_data !== 32'h1111_1111 || lat !== 1) begin
      failures++; $display("FAIL b2b_rd_c got data=%h lat=%0d exp data=11111111 lat=1", rd_data, lat);
    end
    xfer(32'hA008, 1'b0, '0);
    checks++;
    if (rd_data !== 32'hDEADBEEF) begin failures++; $display("FAIL b2b_rd_8 got=%h exp=deadbeef", rd_data); end
    xfer(32'hA004, 1'b0, '0);
    checks++;
    if (rd_data !== 32'h000A_0006) begin failures++; $display("FAIL b2b_status got=%h exp=000a0006", rd_data); end
  endtask

  task automatic test_reset_mid_wait();
    bit seen;
    xfer(32'hA000, 1'b1, 32'h7);
    psel = 1'b1; penable = 1'b0; paddr = 32'hA008; pwrite = 1'b1; pwdata = 32'h55;
    @(posedge pclk); #1 penable = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge pclk); seen |= pready;
      @(posedge pclk); #1;
    end
    preset = 1'b1; psel = 1'b0; penable = 1'b0;
    @(negedge pclk); seen |= pready;
    @(posedge pclk); #1 preset = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge pclk); seen |= pready;
    end
    checks++;
    if (seen !== 1'b0) begin failures++; $display("FAIL midrst_pready got=1 exp=0"); end
    @(posedge pclk); #1;
    xfer(32'hA008, 1'b0, '0);
    checks++;
    if (rd_data !== 32'h0 || lat !== 1) begin
      failures++; $display("FAIL midrst_scratch got data=%h lat=%0d exp data=0 lat=1", rd_data, lat);
    end
    xfer(32'hA000, 1'b0, '0);
    checks++;
    if (rd_data !== 32'h0) begin failures++; $display("FAIL midrst_ctrl got=%h exp=0", rd_data); end
  endtask

  initial begin
    checks = 0; failures = 0;
    preset = 1'b1; psel = 1'b0; penable = 1'b0;
    paddr = '0; pwrite = 1'b0; pwdata = '0;
    test_reset();
    @(posedge pclk); #1;
    test_write_read();
    test_wait_states();
    test_errors();
    test_abort();
    test_back_to_back();
    test_reset_mid_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
